// File: rtl/instr_issue_arbiter.sv
// Round-robin arbiter that packs one requester's encoder fields into a 21-bit
// instruction and writes it to instruction memory at an auto-incrementing address.
module instr_issue_arbiter #(
    parameter  int NREQ      = 4,
    parameter  int MEM_DEPTH = 256,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [5*NREQ-1:0]    req_opcode,
    input  logic [4*NREQ-1:0]    req_rsd,
    input  logic [4*NREQ-1:0]    req_rsn,
    input  logic [8*NREQ-1:0]    req_imm,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [20:0]          mem_wdata,
    input  logic                 mem_ready,
    output logic [ADDR_W:0]      instr_count,
    output logic                 full
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    r_grant_idx;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [20:0]         r_mem_wdata;
    logic [ADDR_W:0]     r_instr_count;
    logic                r_full;

    logic                w_any_valid;
    logic [PTR_W-1:0]    w_grant_idx;
    logic [PTR_W-1:0]    w_scan_idx;
    logic [NREQ-1:0]     w_ready;
    logic [20:0]         w_word;
    logic                w_xfer;

    // Pointer increment that wraps at NREQ even when NREQ is not a power of two.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NREQ - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Round-robin search: first valid requester starting at r_rr_ptr.
    always_comb begin
        w_any_valid = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = r_rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_any_valid && req_valid[w_scan_idx]) begin
                w_any_valid = 1'b1;
                w_grant_idx = w_scan_idx;
            end else begin
                w_any_valid = w_any_valid;
            end
            w_scan_idx = wrap_inc(w_scan_idx);
        end
    end

    // One-hot accept and field mux for the granted requester.
    always_comb begin
        w_ready = '0;
        w_word  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant_idx == PTR_W'(k)) begin
                w_word     = {req_opcode[5*k +: 5], req_rsd[4*k +: 4],
                              req_rsn[4*k +: 4], req_imm[8*k +: 8]};
                w_ready[k] = (r_state == ST_IDLE) && w_any_valid && !rst && !clear;
            end else begin
                w_ready[k] = 1'b0;
            end
        end
    end

    assign w_xfer    = |(req_valid & w_ready);
    assign req_ready = w_ready;

    // Main FSM: rst dominates clear; clear drops any pending write but keeps
    // the round-robin pointer and last packed word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_grant_idx   <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_instr_count <= '0;
            r_full        <= 1'b0;
        end else if (clear) begin
            r_state       <= ST_IDLE;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_instr_count <= '0;
            r_full        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_mem_wdata <= w_word;
                        r_grant_idx <= w_grant_idx;
                        r_mem_we    <= 1'b1;
                        r_state     <= ST_WRITE;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        r_instr_count <= r_instr_count + (ADDR_W+1)'(1);
                        r_rr_ptr      <= wrap_inc(r_grant_idx);
                        r_mem_we      <= 1'b0;
                        if (r_mem_addr == ADDR_W'(MEM_DEPTH - 1)) begin
                            r_mem_addr <= '0;
                            r_full     <= 1'b1;
                            r_state    <= ST_FULL;
                        end else begin
                            r_mem_addr <= r_mem_addr + ADDR_W'(1);
                            r_state    <= ST_IDLE;
                        end
                    end else begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_FULL: begin
                    r_mem_we <= 1'b0;
                    r_state  <= ST_FULL;
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign instr_count = r_instr_count;
    assign full        = r_full;

endmodule
